dmem_bytelane: RTL



---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_bytelane_if.sv | 22 ++
 rtl/dmem_sram.sv | 39 +++
 rtl/dmem_bytelane.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: RV32I size codes, FSM states
// and the load extraction/extension helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    // Pick the addressed byte/half out of a stored word and sign- or zero-extend it.
    function automatic logic [31:0] ext_load(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  funct3);
        logic [31:0] shifted_s;
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] res_s;
        shifted_s = word >> {lane, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    res_s = {{24{byte_s[7]}}, byte_s};
            F3_H:    res_s = {{16{half_s[15]}}, half_s};
            F3_W:    res_s = word;
            F3_BU:   res_s = {24'h00_0000, byte_s};
            F3_HU:   res_s = {16'h0000, half_s};
            default: res_s = 32'h0000_0000;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bus between the datapath (master) and the data memory (slave).
interface dmem_bytelane_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_sram.sv
// Single-port DEPTH x 32 word array with per-byte write strobes and a registered read.
module dmem_sram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    strb,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Byte-strobed write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (en && !we) begin
            rdata_r <= mem_r[idx];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/dmem_bytelane.sv
// RV32I data memory: decode, legality/alignment/range checks, clear-after-reset walk,
// one-cycle registered response with byte/half extraction and extension.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter logic [31:0] BASE         = 32'h0000_0000,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_bytelane_if.slave bus
);
    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam logic [31:0]   SPAN      = 32'(DEPTH * 4);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    localparam state_e        RST_STATE = CLEAR_ON_RST ? INIT : IDLE;

    state_e        state_r, state_next;
    logic [AW-1:0] cnt_r, cnt_next;
    logic          ready_r;

    logic [32:0]   diff_s;
    logic [31:0]   off_s;
    logic [1:0]    lane_s;
    logic [AW-1:0] idx_s;
    logic          oor_s, misal_s, illegal_s, err_s, accept_s;
    logic [3:0]    st_strb_s;
    logic [31:0]   st_data_s;

    logic          mem_en_s, mem_we_s;
    logic [3:0]    mem_strb_s;
    logic [AW-1:0] mem_idx_s;
    logic [31:0]   mem_wdata_s, mem_rdata_s;

    logic          rvalid_r, err_r, ld_r;
    logic [1:0]    lane_r;
    logic [2:0]    f3_r;

    // The 33rd bit of the subtraction is the borrow, i.e. addr below BASE.
    assign diff_s   = {1'b0, bus.addr} - {1'b0, BASE};
    assign off_s    = diff_s[31:0];
    assign oor_s    = diff_s[32] | (off_s >= SPAN);
    assign lane_s   = bus.addr[1:0];
    assign idx_s    = off_s[2 +: AW];
    assign err_s    = oor_s | misal_s | illegal_s;
    assign accept_s = bus.req & ready_r & ~rst;

    // funct3 legality, alignment and store lane/data replication.
    always_comb begin
        illegal_s = 1'b0;
        misal_s   = 1'b0;
        st_strb_s = 4'b0000;
        st_data_s = bus.wdata;
        case (bus.funct3)
            F3_B: begin
                st_strb_s = 4'b0001 << lane_s;
                st_data_s = {4{bus.wdata[7:0]}};
            end
            F3_H: begin
                misal_s   = lane_s[0];
                st_strb_s = lane_s[1] ? 4'b1100 : 4'b0011;
                st_data_s = {2{bus.wdata[15:0]}};
            end
            F3_W: begin
                misal_s   = |lane_s;
                st_strb_s = 4'b1111;
            end
            F3_BU:   illegal_s = bus.we;
            F3_HU: begin
                illegal_s = bus.we;
                misal_s   = lane_s[0];
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Next state and array port control: zero-fill walk in INIT, accesses in IDLE.
    always_comb begin
        state_next  = state_r;
        cnt_next    = cnt_r;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_strb_s  = 4'b0000;
        mem_idx_s   = idx_s;
        mem_wdata_s = st_data_s;
        case (state_r)
            INIT: begin
                mem_en_s    = ~rst;
                mem_we_s    = 1'b1;
                mem_strb_s  = 4'b1111;
                mem_idx_s   = cnt_r;
                mem_wdata_s = 32'h0000_0000;
                if (cnt_r == LAST) begin
                    state_next = IDLE;
                    cnt_next   = {AW{1'b0}};
                end else begin
                    cnt_next = cnt_r + 1'b1;
                end
            end
            IDLE: begin
                if (accept_s) begin
                    mem_en_s   = 1'b1;
                    mem_we_s   = bus.we & ~err_s;
                    mem_strb_s = (bus.we & ~err_s) ? st_strb_s : 4'b0000;
                end else begin
                    mem_en_s = 1'b0;
                end
            end
            default: state_next = RST_STATE;
        endcase
    end

    // FSM state, walk counter and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RST_STATE;
            cnt_r   <= {AW{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            ready_r <= (state_next == IDLE);
        end
    end

    // Response qualifiers captured alongside the array read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            ld_r     <= 1'b0;
            lane_r   <= 2'b00;
            f3_r     <= 3'b000;
        end else begin
            rvalid_r <= accept_s;
            err_r    <= accept_s & err_s;
            ld_r     <= accept_s & ~bus.we & ~err_s;
            lane_r   <= lane_s;
            f3_r     <= bus.funct3;
        end
    end

    dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .strb  (mem_strb_s),
        .idx   (mem_idx_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    assign bus.ready  = ready_r;
    assign bus.rvalid = rvalid_r;
    assign bus.err    = err_r;
    assign bus.rdata  = ld_r ? ext_load(mem_rdata_s, lane_r, f3_r) : 32'h0000_0000;
endmodule
